// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NREQ requesters. A grant is
// held until the RAM reports the matching completion or the wait times out.
// Each requester then gets a one-cycle done or err pulse.
module ram_port_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     ram_address,
  output logic [DW-1:0]     ram_data_out,
  output logic              ram_read_signal,
  output logic              ram_write_signal,
  input  logic [DW-1:0]     ram_data_in,
  input  logic              ram_done_read,
  input  logic              ram_done_write,
  output logic              busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} stateT;

  stateT           stateQ, stateD;
  logic [IW-1:0]   rrQ, rrD;
  logic [IW-1:0]   idxQ, idxD;
  logic            weQ, weD;
  logic [AW-1:0]   addrQ, addrD;
  logic [DW-1:0]   wdataQ, wdataD;
  logic [CW-1:0]   cntQ, cntD;
  logic [NREQ-1:0] gntQ, gntD;
  logic [NREQ-1:0] doneQ, doneD;
  logic [NREQ-1:0] errQ, errD;
  logic [DW-1:0]   rdataQ, rdataD;
  logic [AW-1:0]   ramAddrQ, ramAddrD;
  logic [DW-1:0]   ramDataQ, ramDataD;
  logic            rdQ, rdD;
  logic            wrQ, wrD;

  logic [IW-1:0]   hiIdx, loIdx, pickIdx;
  logic            hiAny;
  logic            matchDone;

  // Round-robin pick: lowest requester above the pointer, else lowest overall (wrap).
  always_comb begin
    hiIdx = '0;
    loIdx = '0;
    hiAny = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        loIdx = IW'(i);
        if (i > int'(rrQ)) begin
          hiIdx = IW'(i);
          hiAny = 1'b1;
        end
      end
    end
    pickIdx = hiAny ? hiIdx : loIdx;
  end

  // Only the completion matching the access direction ends the wait.
  assign matchDone = weQ ? ram_done_write : ram_done_read;

  // Next-state and registered-output logic for the access sequence.
  always_comb begin
    stateD   = stateQ;
    rrD      = rrQ;
    idxD     = idxQ;
    weD      = weQ;
    addrD    = addrQ;
    wdataD   = wdataQ;
    cntD     = cntQ;
    gntD     = gntQ;
    doneD    = '0;
    errD     = '0;
    rdataD   = rdataQ;
    ramAddrD = ramAddrQ;
    ramDataD = ramDataQ;
    rdD      = rdQ;
    wrD      = wrQ;
    unique case (stateQ)
      StIdle: begin
        if (|req) begin
          idxD   = pickIdx;
          weD    = req_we[pickIdx];
          addrD  = req_addr[pickIdx*AW +: AW];
          wdataD = req_wdata[pickIdx*DW +: DW];
          gntD   = NREQ'(1) << pickIdx;
          stateD = StIssue;
        end
      end
      StIssue: begin
        ramAddrD = addrQ;
        ramDataD = wdataQ;
        rdD      = ~weQ;
        wrD      = weQ;
        cntD     = '0;
        stateD   = StWait;
      end
      StWait: begin
        if (matchDone) begin
          if (!weQ) begin
            rdataD = ram_data_in;
          end
          rdD    = 1'b0;
          wrD    = 1'b0;
          doneD  = NREQ'(1) << idxQ;
          stateD = StResp;
        end else if (cntQ == CW'(TIMEOUT)) begin
          rdD    = 1'b0;
          wrD    = 1'b0;
          errD   = NREQ'(1) << idxQ;
          stateD = StResp;
        end else begin
          cntD = cntQ + CW'(1);
        end
      end
      StResp: begin
        // done/err pulse is visible during this state; release the port.
        gntD   = '0;
        rrD    = idxQ;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      stateQ   <= StIdle;
      rrQ      <= IW'(NREQ - 1);
      idxQ     <= '0;
      weQ      <= 1'b0;
      addrQ    <= '0;
      wdataQ   <= '0;
      cntQ     <= '0;
      gntQ     <= '0;
      doneQ    <= '0;
      errQ     <= '0;
      rdataQ   <= '0;
      ramAddrQ <= '0;
      ramDataQ <= '0;
      rdQ      <= 1'b0;
      wrQ      <= 1'b0;
    end else begin
      stateQ   <= stateD;
      rrQ      <= rrD;
      idxQ     <= idxD;
      weQ      <= weD;
      addrQ    <= addrD;
      wdataQ   <= wdataD;
      cntQ     <= cntD;
      gntQ     <= gntD;
      doneQ    <= doneD;
      errQ     <= errD;
      rdataQ   <= rdataD;
      ramAddrQ <= ramAddrD;
      ramDataQ <= ramDataD;
      rdQ      <= rdD;
      wrQ      <= wrD;
    end
  end

  assign gnt              = gntQ;
  assign done             = doneQ;
  assign err              = errQ;
  assign rdata            = rdataQ;
  assign ram_address      = ramAddrQ;
  assign ram_data_out     = ramDataQ;
  assign ram_read_signal  = rdQ;
  assign ram_write_signal = wrQ;
  assign busy             = (stateQ != StIdle);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: table of transactions plus hand-written
// sequences for wrong-direction completion and asynchronous reset mid-wait.
module tb_ram_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int TO   = 4;

  logic              clk = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   gnt, done, err;
  logic [DW-1:0]     rdata, ram_data_out, ram_data_in;
  logic [AW-1:0]     ram_address;
  logic              ram_read_signal, ram_write_signal;
  logic              ram_done_read, ram_done_write, busy;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .ram_address(ram_address), .ram_data_out(ram_data_out),
    .ram_read_signal(ram_read_signal), .ram_write_signal(ram_write_signal),
    .ram_data_in(ram_data_in), .ram_done_read(ram_done_read),
    .ram_done_write(ram_done_write), .busy(busy)
  );

  typedef struct {
    logic [2:0]  rq;
    logic [2:0]  we;
    logic [47:0] addr;
    logic [23:0] wdata;
    int          lat;      // RAM answers this many cycles after the first strobe cycle
    logic [7:0]  ramData;
    int          expIdx;
    logic        expWe;
    logic [15:0] expAddr;
    logic [7:0]  expWdata;
    logic        expErr;
    logic [7:0]  expRdata;
  } vecT;

  int nVec = 0;
  int nMis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one transaction at the current negedge, model the RAM, check the outcome.
  task automatic runTxn(input vecT v, input int n);
    int gntAt = -1, stbFirst = -1, stbLast = -1, stbCnt = 0, endAt = -1;
    logic [2:0] gntVal = '0, doneV = '0, errV = '0, oneHot;
    logic [7:0] rdV = '0;
    logic       busyV = 1'b0, wasWr = 1'b0, bad = 1'b0;
    oneHot    = 3'b001 << v.expIdx;
    req       = v.rq;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    for (int s = 1; s <= 40 && endAt < 0; s++) begin
      @(negedge clk);
      ram_done_read  = 1'b0;
      ram_done_write = 1'b0;
      if (s == 1) check($sformatf("v%0d_pulse_width", n), {done, err}, 6'b0);
      if (gnt != 0 && gntAt < 0) begin
        gntAt  = s;
        gntVal = gnt;
      end
      if (ram_read_signal || ram_write_signal) begin
        if (stbFirst < 0) begin
          stbFirst = s;
          wasWr    = ram_write_signal;
        end
        stbLast = s;
        stbCnt++;
        if (ram_address !== v.expAddr || (ram_read_signal && ram_write_signal) ||
            (v.expWe && ram_data_out !== v.expWdata)) bad = 1'b1;
        if (stbCnt == v.lat + 1) begin
          if (ram_write_signal) ram_done_write = 1'b1;
          else begin
            ram_done_read = 1'b1;
            ram_data_in   = v.ramData;
          end
        end
      end
      if (done != 0 || err != 0) begin
        endAt = s;
        doneV = done;
        errV  = err;
        rdV   = rdata;
        busyV = busy;
      end
    end
    check($sformatf("v%0d_completed", n), endAt > 0, 1);
    check($sformatf("v%0d_gnt", n), gntVal, oneHot);
    check($sformatf("v%0d_strobe_dir", n), wasWr, v.expWe);
    check($sformatf("v%0d_strobe_after_gnt", n), stbFirst - gntAt, 1);
    check($sformatf("v%0d_resp_after_strobe", n), endAt - stbLast, 1);
    check($sformatf("v%0d_strobe_len", n), stbCnt, v.expErr ? TO + 1 : v.lat + 1);
    check($sformatf("v%0d_addr_data_stable", n), bad, 0);
    check($sformatf("v%0d_done", n), doneV, v.expErr ? 3'b000 : oneHot);
    check($sformatf("v%0d_err", n), errV, v.expErr ? oneHot : 3'b000);
    check($sformatf("v%0d_rdata", n), rdV, v.expRdata);
    check($sformatf("v%0d_busy_resp", n), busyV, 1);
  endtask

  // Wait (bounded) for a strobe at a negedge.
  task automatic waitStrobe(input string name);
    int k = 0;
    while (!(ram_read_signal || ram_write_signal) && k < 10) begin
      @(negedge clk);
      k++;
    end
    check(name, ram_read_signal || ram_write_signal, 1);
  endtask

  vecT vecs[10];

  initial begin
    // Round-robin pointer starts at 2, so the first 111 contention goes 0,1,2,0.
    vecs[0] = '{3'b111, 3'b000, {16'h2002, 16'h1001, 16'h0A00}, 24'h0, 0, 8'h11,
                0, 1'b0, 16'h0A00, 8'h00, 1'b0, 8'h11};
    vecs[1] = '{3'b111, 3'b000, {16'h2002, 16'h1001, 16'h0A00}, 24'h0, 1, 8'h22,
                1, 1'b0, 16'h1001, 8'h00, 1'b0, 8'h22};
    vecs[2] = '{3'b111, 3'b100, {16'h2002, 16'h1001, 16'h0A00}, 24'h776655, 0, 8'h99,
                2, 1'b1, 16'h2002, 8'h77, 1'b0, 8'h22};
    vecs[3] = '{3'b111, 3'b000, {16'h2002, 16'h1001, 16'h0A00}, 24'h0, 0, 8'h44,
                0, 1'b0, 16'h0A00, 8'h00, 1'b0, 8'h44};
    vecs[4] = '{3'b101, 3'b000, {16'hBEEF, 16'h1001, 16'hCAFE}, 24'h0, 2, 8'h55,
                2, 1'b0, 16'hBEEF, 8'h00, 1'b0, 8'h55};
    vecs[5] = '{3'b101, 3'b000, {16'hBEEF, 16'h1001, 16'hCAFE}, 24'h0, 0, 8'h66,
                0, 1'b0, 16'hCAFE, 8'h00, 1'b0, 8'h66};
    vecs[6] = '{3'b010, 3'b000, {16'h0000, 16'h1234, 16'h0000}, 24'h0, 3, 8'hA5,
                1, 1'b0, 16'h1234, 8'h00, 1'b0, 8'hA5};
    vecs[7] = '{3'b001, 3'b001, {16'h0000, 16'h0000, 16'h0010}, 24'h00003C, 2, 8'hEE,
                0, 1'b1, 16'h0010, 8'h3C, 1'b0, 8'hA5};
    vecs[8] = '{3'b100, 3'b000, {16'h4444, 16'h0000, 16'h0000}, 24'h0, 99, 8'h00,
                2, 1'b0, 16'h4444, 8'h00, 1'b1, 8'hA5};
    vecs[9] = '{3'b010, 3'b000, {16'h0000, 16'h0042, 16'h0000}, 24'h0, 1, 8'hC3,
                1, 1'b0, 16'h0042, 8'h00, 1'b0, 8'hC3};

    RST = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    ram_data_in = '0; ram_done_read = 1'b0; ram_done_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_gnt_done_err", {gnt, done, err}, 9'b0);
    check("reset_rdata", rdata, 0);
    check("reset_ram_bus", {ram_address, ram_data_out}, 24'b0);
    check("reset_strobes_busy", {ram_read_signal, ram_write_signal, busy}, 3'b0);
    RST = 1'b0;

    for (int i = 0; i < 10; i++) runTxn(vecs[i], i);

    // Wrong-direction completion is ignored; request changes after grant are ignored.
    req = 3'b001; req_we = 3'b000; req_addr = {16'h0, 16'h0, 16'h5555};
    @(negedge clk);
    waitStrobe("t5_strobe");
    check("t5_addr", ram_address, 16'h5555);
    req = 3'b000; req_addr = {16'h0, 16'h0, 16'hFFFF};
    ram_done_write = 1'b1;
    @(negedge clk);
    ram_done_write = 1'b0;
    check("t5_still_reading", ram_read_signal, 1);
    check("t5_no_done", {done, err}, 6'b0);
    check("t5_gnt_held", gnt, 3'b001);
    check("t5_addr_held", ram_address, 16'h5555);
    ram_done_read = 1'b1;
    ram_data_in   = 8'h5A;
    @(negedge clk);
    ram_done_read = 1'b0;
    check("t5_done", done, 3'b001);
    check("t5_rdata", rdata, 8'h5A);
    check("t5_strobe_dropped", ram_read_signal, 0);
    @(negedge clk);
    check("t5_done_pulse_end", done, 3'b000);
    check("t5_idle", {busy, gnt}, 4'b0);

    // Asynchronous reset in WAIT, then requester 1 wins first over 2.
    req = 3'b100; req_addr = {16'h7777, 16'h0, 16'h0};
    @(negedge clk);
    waitStrobe("t6_strobe");
    check("t6_gnt_before", gnt, 3'b100);
    #2 RST = 1'b1;
    #1;
    check("t6_async_gnt", gnt, 3'b000);
    check("t6_async_strobes", {ram_read_signal, ram_write_signal}, 2'b00);
    check("t6_async_busy", busy, 0);
    check("t6_async_rdata", rdata, 0);
    req = 3'b110;
    req_addr = {16'h2222, 16'h1111, 16'h0};
    @(negedge clk);
    RST = 1'b0;
    begin
      int k = 0;
      while (gnt == 0 && k < 5) begin
        @(negedge clk);
        k++;
      end
    end
    check("t6_first_gnt", gnt, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
